// File: rtl/hex_seg_pkg.sv
// Shared definitions for the seven-segment read-back path: glyph table,
// segment bit order, FSM state type and digit width.
package hex_seg_pkg;

    // Segment bit order on the bus: bit0 = a ... bit6 = g
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;

    // Width of one decoded hex digit and of the digit-select index
    localparam int DIGIT_W = 4;
    localparam int DSEL_W  = 3;

    // Active-high glyphs; entry i is the pattern that shows hex digit i
    localparam logic [15:0][SEG_W-1:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/hex_seg_reader_if.sv
// Bus bundle between the segment reader and whoever drives the panel side
// and consumes the assembled word.
interface hex_seg_reader_if
    import hex_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) ();

    logic                          start;
    logic [SEG_W-1:0]              seg_in;
    logic [DSEL_W-1:0]             dig_sel;
    logic                          busy;
    logic [DIGIT_W*NUM_DIGITS-1:0] odata;
    logic                          valid;
    logic                          err;
    logic [NUM_DIGITS-1:0]         err_mask;

    // Requester side: issues scans, presents the selected digit's segments
    modport master (
        output start,
        output seg_in,
        input  dig_sel,
        input  busy,
        input  odata,
        input  valid,
        input  err,
        input  err_mask
    );

    // Reader side
    modport slave (
        input  start,
        input  seg_in,
        output dig_sel,
        output busy,
        output odata,
        output valid,
        output err,
        output err_mask
    );

endinterface

// File: rtl/hex_seg_reader_seg7_to_nibble.sv
// Combinational seven-segment to hex decoder. Only exact glyph matches are
// legal; anything else (blank included) yields nibble 0 with legal low.
module seg7_to_nibble
    import hex_seg_pkg::*;
(
    input  logic [SEG_G:SEG_A]   seg,
    output logic [DIGIT_W-1:0]   nibble,
    output logic                 legal
);

    // Search the glyph table for an exact match
    always_comb begin
        nibble = '0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i]) begin
                nibble = DIGIT_W'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hex_seg_reader.sv
// Seven-segment read-back scanner: steps dig_sel across the panel, waits for
// the multiplexed bus to settle, decodes each digit and publishes a word.
// Build option: SEG_ACTIVE_LOW_EN inverts the registered segments before
// decoding, for common-anode panels.
module hex_seg_reader
    import hex_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    hex_seg_reader_if.slave  bus
);

    localparam int WORD_W = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DSEL_W-1:0] LAST_DIG = DSEL_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [DSEL_W-1:0]   dig_sel_q, dig_sel_d;
    logic [SEG_W-1:0]    seg_q, seg_d;
    logic [WORD_W-1:0]   shadow_word_q, shadow_word_d;
    logic [NUM_DIGITS-1:0] shadow_mask_q, shadow_mask_d;
    logic [WORD_W-1:0]   odata_q, odata_d;
    logic                err_q, err_d;
    logic [NUM_DIGITS-1:0] err_mask_q, err_mask_d;
    logic                valid_q, valid_d;

    logic [SEG_W-1:0]    seg_dec;
    logic [DIGIT_W-1:0]  dec_nibble;
    logic                dec_legal;

    assign seg_d = bus.seg_in;

    // Present the registered segments to the decoder in active-high form
    always_comb begin
`ifdef SEG_ACTIVE_LOW_EN
        seg_dec = ~seg_q;
`else
        seg_dec = seg_q;
`endif
    end

    seg7_to_nibble u_decode (
        .seg    (seg_dec),
        .nibble (dec_nibble),
        .legal  (dec_legal)
    );

    // Scan sequencing: settle, sample each digit, then publish on DONE
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        dig_sel_d     = dig_sel_q;
        shadow_word_d = shadow_word_q;
        shadow_mask_d = shadow_mask_q;
        odata_d       = odata_q;
        err_d         = err_q;
        err_mask_d    = err_mask_q;
        valid_d       = 1'b0;

        case (state_q)
            IDLE: begin
                dig_sel_d = '0;
                if (bus.start) begin
                    state_d       = SETTLE;
                    settle_cnt_d  = '0;
                    shadow_word_d = '0;
                    shadow_mask_d = '0;
                end
            end

            SETTLE: begin
                if (settle_cnt_q == LAST_CNT) begin
                    settle_cnt_d = '0;
                    state_d      = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end

            SAMPLE: begin
                shadow_word_d[dig_sel_q*DIGIT_W +: DIGIT_W] =
                    dec_legal ? dec_nibble : '0;
                if (!dec_legal) begin
                    shadow_mask_d[dig_sel_q] = 1'b1;
                end
                if (dig_sel_q == LAST_DIG) begin
                    state_d = DONE;
                end else begin
                    dig_sel_d    = dig_sel_q + 1'b1;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end

            DONE: begin
                odata_d    = shadow_word_q;
                err_mask_d = shadow_mask_q;
                err_d      = |shadow_mask_q;
                valid_d    = 1'b1;
                dig_sel_d  = '0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including the input register, clears on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            dig_sel_q     <= '0;
            seg_q         <= '0;
            shadow_word_q <= '0;
            shadow_mask_q <= '0;
            odata_q       <= '0;
            err_q         <= 1'b0;
            err_mask_q    <= '0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            dig_sel_q     <= dig_sel_d;
            seg_q         <= seg_d;
            shadow_word_q <= shadow_word_d;
            shadow_mask_q <= shadow_mask_d;
            odata_q       <= odata_d;
            err_q         <= err_d;
            err_mask_q    <= err_mask_d;
            valid_q       <= valid_d;
        end
    end

    assign bus.dig_sel  = dig_sel_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.odata    = odata_q;
    assign bus.valid    = valid_q;
    assign bus.err      = err_q;
    assign bus.err_mask = err_mask_q;

endmodule

// File: tb/tb_hex_seg_reader.sv
// Bench for hex_seg_reader. A panel model shows one raw pattern per digit
// on seg_in according to dig_sel; each accepted start pushes the expected
// word into a scoreboard that a separate monitor drains on valid.
module tb_hex_seg_reader;

    localparam int NUM_DIGITS    = 8;
    localparam int SETTLE_CYCLES = 2;
    localparam int SLOT          = SETTLE_CYCLES + 1;
    localparam int SCAN_EDGES    = NUM_DIGITS * SLOT;
    localparam int LATENCY       = SCAN_EDGES + 1;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  mask;
        int          edge_no;
    } exp_t;

    logic clk;
    logic rst;

    hex_seg_reader_if #(.NUM_DIGITS(NUM_DIGITS)) bus ();

    hex_seg_reader #(
        .NUM_DIGITS    (NUM_DIGITS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] ref_glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [6:0]  pats [NUM_DIGITS];
    exp_t        sb [$];
    int          edge_cnt = 0;
    bit          active = 0;
    int          start_edge = 0;
    bit          glitch_en = 0;
    int          glitch_k;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_word = '0;
    logic [7:0]  last_mask = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Raw bus value for an active-high pattern in the current build
    function automatic logic [6:0] busPattern(input logic [6:0] x);
`ifdef SEG_ACTIVE_LOW_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic logic [6:0] glyphRaw(input int n);
        return busPattern(ref_glyph[n]);
    endfunction

    // Hex value shown by a raw bus pattern, -1 when it is not a glyph
    function automatic int lookup(input logic [6:0] raw);
        logic [6:0] lit;
        lit = busPattern(raw);
        for (int i = 0; i < 16; i++) begin
            if (lit == ref_glyph[i]) return i;
        end
        return -1;
    endfunction

    function automatic exp_t expectFor();
        exp_t e;
        int   idx;
        e.word = '0;
        e.mask = '0;
        e.edge_no = 0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            idx = lookup(pats[d]);
            if (idx < 0) e.mask[d] = 1'b1;
            else e.word[4*d +: 4] = 4'(idx);
        end
        return e;
    endfunction

    function automatic bit modelBusy();
        return active && ((edge_cnt - start_edge) <= SCAN_EDGES);
    endfunction

    function automatic int modelDigSel();
        int d;
        if (!modelBusy()) return 0;
        d = (edge_cnt - start_edge) / SLOT;
        return (d > NUM_DIGITS - 1) ? NUM_DIGITS - 1 : d;
    endfunction

    // Panel model; optionally corrupts the bus in the cycle it must not be captured
    always_comb begin
        glitch_k = edge_cnt - start_edge;
        if (glitch_en && active && glitch_k < SCAN_EDGES &&
            (glitch_k % SLOT) == SETTLE_CYCLES)
            bus.seg_in = 7'h01;
        else
            bus.seg_in = pats[bus.dig_sel];
    end

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d",
                     name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: pops the scoreboard on valid and checks held outputs every cycle
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (bus.valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 64'(bus.valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("valid_latency", 64'(edge_cnt), 64'(e.edge_no));
                    last_word = e.word;
                    last_mask = e.mask;
                end
            end
            checkOutput("odata", 64'(bus.odata), 64'(last_word));
            checkOutput("err_mask", 64'(bus.err_mask), 64'(last_mask));
            checkOutput("err", 64'(bus.err), 64'(|last_mask));
            checkOutput("busy", 64'(bus.busy), 64'(modelBusy()));
            checkOutput("dig_sel", 64'(bus.dig_sel), 64'(modelDigSel()));
        end
    end

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic loadWord(input logic [31:0] w);
        for (int d = 0; d < NUM_DIGITS; d++) pats[d] = glyphRaw(int'(w[4*d +: 4]));
    endtask

    // One-cycle start pulse; called and returns just after a rising edge
    task automatic applyStimulus();
        int   sample_edge;
        bit   accept;
        exp_t e;
        sample_edge = edge_cnt + 1;
        accept = !active || (sample_edge > start_edge + LATENCY);
        e = expectFor();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (accept) begin
            active     = 1'b1;
            start_edge = sample_edge;
            e.edge_no  = sample_edge + LATENCY;
            sb.push_back(e);
        end
    endtask

    task automatic waitIdle(input int max_cycles);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("scan_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_odata"}, 64'(bus.odata), 64'd0);
        checkOutput({tag, "_err"}, 64'(bus.err), 64'd0);
        checkOutput({tag, "_err_mask"}, 64'(bus.err_mask), 64'd0);
        checkOutput({tag, "_valid"}, 64'(bus.valid), 64'd0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_dig_sel"}, 64'(bus.dig_sel), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bus.start = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) pats[d] = 7'h00;
        rst = 1'b1;
        #2 rst = 1'b0;
        waitEdges(3);
        checkAllZero("reset");
        rst = 1'b1;
        waitEdges(2);

        // Plain word, all digits legal
        loadWord(32'h1234ABCD);
        applyStimulus();
        waitIdle(LATENCY + 5);

        // Blank on digit 3
        loadWord(32'h1234ABCD);
        pats[3] = busPattern(7'h00);
        applyStimulus();
        waitIdle(LATENCY + 5);

        // Starts during the scan and during DONE are dropped; one in the valid cycle runs
        loadWord(32'hCAFE5A17);
        applyStimulus();
        waitEdges(5);
        applyStimulus();
        waitEdges(SCAN_EDGES - 6);
        applyStimulus();
        loadWord(32'h0F1E2D3C);
        applyStimulus();
        waitIdle(LATENCY + 5);

        // Reset in the middle of digit 4
        loadWord(32'h89ABCDEF);
        applyStimulus();
        waitEdges(4 * SLOT);
        checkOutput("dig_sel_before_reset", 64'(bus.dig_sel), 64'd4);
        rst = 1'b0;
        active = 1'b0;
        sb.delete();
        last_word = '0;
        last_mask = '0;
        #1;
        checkAllZero("abort");
        waitEdges(3);
        rst = 1'b1;
        waitEdges(LATENCY + 3);
        loadWord(32'h76543210);
        applyStimulus();
        waitIdle(LATENCY + 5);

        // All-F word, then a pattern that reads as F only on active-low panels
        loadWord(32'hFFFFFFFF);
        applyStimulus();
        waitIdle(LATENCY + 5);
        for (int d = 0; d < NUM_DIGITS; d++) pats[d] = 7'h0E;
        applyStimulus();
        waitIdle(LATENCY + 5);

        // Bus corruption confined to the sample cycle must not be captured
        glitch_en = 1'b1;
        loadWord(32'h5EED1234);
        applyStimulus();
        waitIdle(LATENCY + 5);

        // Random patterns, gaps and stray starts
        for (int it = 0; it < 40; it++) begin
            if (!modelBusy()) begin
                glitch_en = ($urandom_range(1) == 1);
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    if ($urandom_range(3) == 0) pats[d] = 7'($urandom_range(127));
                    else pats[d] = glyphRaw(int'($urandom_range(15)));
                end
            end
            applyStimulus();
            waitEdges(int'($urandom_range(LATENCY + 6)));
        end
        waitIdle(2 * LATENCY);
        waitEdges(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
